control_unit_mc: RTL and testbench

Multicycle MIPS main control FSM. Decodes the opcode latched in the instruction register and sequences the datapath one state per clock. It drives every select line of the datapath's 2:1 and 4:1 32-bit multiplexers (IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSource) and all register/memory write enables. It sits directly upstream of those muxes and of the PC, IR, register file and memory.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/control_unit_mc.sv | 106 ++++++++++
 tb/tb_control_unit_mc.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM state encoding and datapath select encodings shared by control and datapath
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        SRCB_B     = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    // First execution state reached from DECODE; unknown opcodes retire as a NOP back to FETCH
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_RTYPE:     return S_EXEC;
            OP_BEQ:       return S_BRANCH;
            OP_ADDI:      return S_ADDIEX;
            OP_J:         return S_JUMP;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle MIPS main control FSM driving datapath selects and write enables
module control_unit_mc
    import mips_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    state_t state;

    assign State = state;

    // State register and next-state sequencing; Opcode only matters in DECODE and MEMADR
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_RST;
        else
            case (state)
                S_RST:    state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= decode_target(Opcode);
                S_MEMADR: state <= (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_EXEC:   state <= S_RWB;
                S_ADDIEX: state <= S_ADDIWB;
                default:  state <= S_FETCH;
            endcase
    end

    // Moore output decode; only PCWrite in BRANCH looks at an input (Zero)
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSource = PCSRC_ALUOUT;
                PCWrite  = Zero;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: random instruction stream with mid-instruction resets checked against an instruction-level model
module tb_control_unit_mc;

    localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMRD = 4, T_MEMWB = 5, T_MEMWR = 6;
    localparam int T_EXEC = 7, T_RWB = 8, T_BRANCH = 9, T_ADDIEX = 10, T_ADDIWB = 11, T_JUMP = 12;
    localparam int CYCLES = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    control_unit_mc dut (
        .Clk(clk), .Reset(reset), .Opcode(opcode), .Zero(zero),
        .PCWrite(pc_write), .IorD(iord), .MemRead(mem_read), .MemWrite(mem_write),
        .IRWrite(ir_write), .RegDst(reg_dst), .MemtoReg(mem_to_reg), .RegWrite(reg_write),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op), .PCSource(pc_source),
        .State(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Control word per state: {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [14:0] exp_ctl(input int s, input logic z);
        case (s)
            T_FETCH:            return 15'b1_0_1_0_1_0_0_0_0_01_00_00;
            T_DECODE:           return 15'b0_0_0_0_0_0_0_0_0_11_00_00;
            T_MEMADR, T_ADDIEX: return 15'b0_0_0_0_0_0_0_0_1_10_00_00;
            T_MEMRD:            return 15'b0_1_1_0_0_0_0_0_0_00_00_00;
            T_MEMWB:            return 15'b0_0_0_0_0_0_1_1_0_00_00_00;
            T_MEMWR:            return 15'b0_1_0_1_0_0_0_0_0_00_00_00;
            T_EXEC:             return 15'b0_0_0_0_0_0_0_0_1_00_10_00;
            T_RWB:              return 15'b0_0_0_0_0_1_0_1_0_00_00_00;
            T_BRANCH:           return {z, 14'b0_0_0_0_0_0_0_1_00_01_01};
            T_ADDIWB:           return 15'b0_0_0_0_0_0_0_1_0_00_00_00;
            T_JUMP:             return 15'b1_0_0_0_0_0_0_0_0_00_00_10;
            default:            return 15'b0;
        endcase
    endfunction

    // States an instruction visits after FETCH, before the next FETCH
    task automatic instr_path(input logic [5:0] op, output int p[$]);
        case (op)
            6'h23:   p = '{T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB};
            6'h2B:   p = '{T_DECODE, T_MEMADR, T_MEMWR};
            6'h00:   p = '{T_DECODE, T_EXEC, T_RWB};
            6'h04:   p = '{T_DECODE, T_BRANCH};
            6'h08:   p = '{T_DECODE, T_ADDIEX, T_ADDIWB};
            6'h02:   p = '{T_DECODE, T_JUMP};
            default: p = '{T_DECODE};
        endcase
    endtask

    initial begin
        logic [5:0] directed[10];
        logic [5:0] legal[6];
        logic [5:0] cur_op;
        int q[$];
        int exp_st;
        int rst_left;
        int n_instr;
        int idx;
        bit did_rd_rst, did_ex_rst;
        directed = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h23, 6'h00};
        legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        cur_op = 6'h00;
        exp_st = T_RST;
        n_instr = 0;
        idx = 0;
        did_rd_rst = 1'b0;
        did_ex_rst = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        rst_left = 2;
        for (int c = 0; c < CYCLES; c++) begin
            if (exp_st == T_FETCH) begin
                idx = n_instr;
                n_instr++;
                if (idx < 10)
                    cur_op = directed[idx];
                else begin
                    int r;
                    r = int'($urandom_range(0, 7));
                    cur_op = (r < 6) ? legal[r] : 6'($urandom);
                end
            end
            if (rst_left == 0) begin
                if (exp_st == T_MEMRD && !did_rd_rst) begin
                    rst_left = 1;
                    did_rd_rst = 1'b1;
                end else if (exp_st == T_EXEC && !did_ex_rst) begin
                    rst_left = 1;
                    did_ex_rst = 1'b1;
                end else if (idx >= 10 && $urandom_range(0, 59) == 0)
                    rst_left = int'($urandom_range(1, 3));
            end
            reset = (rst_left > 0);
            zero = (idx < 10) ? idx[0] : 1'($urandom);
            opcode = (exp_st == T_RST || exp_st == T_FETCH) ? 6'($urandom) : cur_op;
            @(negedge clk);
            check("state", 32'(state), 32'(exp_st));
            check("ctl", 32'({pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                              alu_src_a, alu_src_b, alu_op, pc_source}), 32'(exp_ctl(exp_st, zero)));
            if (reset) begin
                exp_st = T_RST;
                q.delete();
            end else if (exp_st == T_RST)
                exp_st = T_FETCH;
            else if (exp_st == T_FETCH) begin
                instr_path(cur_op, q);
                exp_st = q.pop_front();
            end else
                exp_st = (q.size() > 0) ? q.pop_front() : T_FETCH;
            @(posedge clk);
            #1;
            if (rst_left > 0)
                rst_left--;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
